// File: rtl/conv_pkg.sv
`default_nettype none
//==============================================================================
// Package  : conv_pkg
// Brief    : Shared FSM encoding, default layer geometry and sizing helpers
//            for the convolution sequencer.
// Revision : 1.0 - initial release
//==============================================================================
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int C_IN_WIDTH     = 28;
    localparam int C_IN_CHANNELS  = 1;
    localparam int C_OUT_CHANNELS = 16;
    localparam int C_KERNEL_SIZE  = 5;
    localparam int C_PADDING      = 2;

    // Keeps degenerate dimensions (e.g. a single channel) at a legal 1-bit width
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int beats_per_output(input int k, input int ic);
        return k * k * ic;
    endfunction

    function automatic int total_beats(input int w, input int oc, input int k, input int ic);
        return w * w * oc * beats_per_output(k, ic);
    endfunction

    localparam int C_BEATS_PER_OUT = beats_per_output(C_KERNEL_SIZE, C_IN_CHANNELS);
    localparam int C_TOTAL_BEATS   = total_beats(C_IN_WIDTH, C_OUT_CHANNELS,
                                                 C_KERNEL_SIZE, C_IN_CHANNELS);

endpackage
`default_nettype wire

// File: rtl/conv_sequencer_if.sv
`default_nettype none
//==============================================================================
// Interface : conv_sequencer_if
// Brief     : Beat-descriptor valid/ready bus from sequencer to MAC unit.
// Revision  : 1.0 - initial release
//==============================================================================
interface conv_sequencer_if #(
    parameter int IN_WIDTH     = conv_pkg::C_IN_WIDTH,
    parameter int IN_CHANNELS  = conv_pkg::C_IN_CHANNELS,
    parameter int OUT_CHANNELS = conv_pkg::C_OUT_CHANNELS,
    parameter int KERNEL_SIZE  = conv_pkg::C_KERNEL_SIZE
) ();
    import conv_pkg::*;

    localparam int FM_AW  = clog2_min1(IN_WIDTH * IN_WIDTH * IN_CHANNELS);
    localparam int W_AW   = clog2_min1(KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS * OUT_CHANNELS);
    localparam int B_AW   = clog2_min1(OUT_CHANNELS);
    localparam int OUT_AW = clog2_min1(IN_WIDTH * IN_WIDTH * OUT_CHANNELS);

    logic              issue_valid;
    logic              issue_ready;
    logic [FM_AW-1:0]  fm_addr;
    logic [W_AW-1:0]   w_addr;
    logic [B_AW-1:0]   bias_addr;
    logic [OUT_AW-1:0] out_addr;
    logic              pad_zero;
    logic              acc_first;
    logic              acc_last;

    modport master (
        output issue_valid, fm_addr, w_addr, bias_addr, out_addr,
               pad_zero, acc_first, acc_last,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, fm_addr, w_addr, bias_addr, out_addr,
               pad_zero, acc_first, acc_last,
        output issue_ready
    );

endinterface
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
//==============================================================================
// Module   : conv_addr_gen
// Brief    : Combinational map from loop indices (i,j,c,m,n,k) to the MAC
//            beat descriptor: addresses, padding and accumulate flags.
// Revision : 1.0 - initial release
//==============================================================================
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IN_WIDTH     = C_IN_WIDTH,
    parameter int IN_CHANNELS  = C_IN_CHANNELS,
    parameter int OUT_CHANNELS = C_OUT_CHANNELS,
    parameter int KERNEL_SIZE  = C_KERNEL_SIZE,
    parameter int PADDING      = C_PADDING
) (
    input  wire [clog2_min1(IN_WIDTH)-1:0]     idx_i,
    input  wire [clog2_min1(IN_WIDTH)-1:0]     idx_j,
    input  wire [clog2_min1(OUT_CHANNELS)-1:0] idx_c,
    input  wire [clog2_min1(KERNEL_SIZE)-1:0]  idx_m,
    input  wire [clog2_min1(KERNEL_SIZE)-1:0]  idx_n,
    input  wire [clog2_min1(IN_CHANNELS)-1:0]  idx_k,
    output logic [clog2_min1(IN_WIDTH*IN_WIDTH*IN_CHANNELS)-1:0]                   fm_addr,
    output logic [clog2_min1(KERNEL_SIZE*KERNEL_SIZE*IN_CHANNELS*OUT_CHANNELS)-1:0] w_addr,
    output logic [clog2_min1(OUT_CHANNELS)-1:0]                                    bias_addr,
    output logic [clog2_min1(IN_WIDTH*IN_WIDTH*OUT_CHANNELS)-1:0]                  out_addr,
    output logic pad_zero,
    output logic acc_first,
    output logic acc_last,
    output logic is_final
);

    localparam int FM_AW  = clog2_min1(IN_WIDTH * IN_WIDTH * IN_CHANNELS);
    localparam int W_AW   = clog2_min1(KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS * OUT_CHANNELS);
    localparam int B_AW   = clog2_min1(OUT_CHANNELS);
    localparam int OUT_AW = clog2_min1(IN_WIDTH * IN_WIDTH * OUT_CHANNELS);

    // Signed 32-bit tap coordinates: wide enough that i+m-P can never wrap
    int w_ri;
    int w_ci;

    assign w_ri = int'(idx_i) + int'(idx_m) - PADDING;
    assign w_ci = int'(idx_j) + int'(idx_n) - PADDING;

    assign pad_zero = (w_ri < 0) || (w_ri >= IN_WIDTH) || (w_ci < 0) || (w_ci >= IN_WIDTH);

    assign fm_addr = pad_zero ? '0
                   : FM_AW'((w_ri * IN_WIDTH + w_ci) * IN_CHANNELS + int'(idx_k));

    assign w_addr = W_AW'((int'(idx_m) * KERNEL_SIZE + int'(idx_n)) * IN_CHANNELS * OUT_CHANNELS
                          + int'(idx_k) * OUT_CHANNELS + int'(idx_c));

    assign bias_addr = B_AW'(idx_c);

    assign out_addr = OUT_AW'((int'(idx_i) * IN_WIDTH + int'(idx_j)) * OUT_CHANNELS + int'(idx_c));

    assign acc_first = (int'(idx_m) == 0) && (int'(idx_n) == 0) && (int'(idx_k) == 0);

    assign acc_last  = (int'(idx_m) == KERNEL_SIZE - 1) && (int'(idx_n) == KERNEL_SIZE - 1)
                    && (int'(idx_k) == IN_CHANNELS - 1);

    assign is_final  = acc_last && (int'(idx_c) == OUT_CHANNELS - 1)
                    && (int'(idx_i) == IN_WIDTH - 1) && (int'(idx_j) == IN_WIDTH - 1);

endmodule
`default_nettype wire

// File: rtl/conv_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : conv_sequencer
// Brief    : Walks (i,j,c,m,n,k) for one convolution layer and issues one
//            registered MAC beat descriptor per valid/ready handshake.
// Revision : 1.0 - initial release
//==============================================================================
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int IN_WIDTH     = C_IN_WIDTH,
    parameter int IN_CHANNELS  = C_IN_CHANNELS,
    parameter int OUT_CHANNELS = C_OUT_CHANNELS,
    parameter int KERNEL_SIZE  = C_KERNEL_SIZE,
    parameter int PADDING      = C_PADDING
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  start,
    output logic busy,
    output logic done,
    conv_sequencer_if.master bus
);

    localparam int IW     = clog2_min1(IN_WIDTH);
    localparam int CW     = clog2_min1(OUT_CHANNELS);
    localparam int KW     = clog2_min1(KERNEL_SIZE);
    localparam int ICW    = clog2_min1(IN_CHANNELS);
    localparam int FM_AW  = clog2_min1(IN_WIDTH * IN_WIDTH * IN_CHANNELS);
    localparam int W_AW   = clog2_min1(KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS * OUT_CHANNELS);
    localparam int B_AW   = clog2_min1(OUT_CHANNELS);
    localparam int OUT_AW = clog2_min1(IN_WIDTH * IN_WIDTH * OUT_CHANNELS);

    state_t r_state, w_state_nxt;

    // Indices of the beat currently presented on the bus
    logic [IW-1:0]  r_i, r_j, w_i_inc, w_j_inc, w_sel_i, w_sel_j;
    logic [CW-1:0]  r_c, w_c_inc, w_sel_c;
    logic [KW-1:0]  r_m, r_n, w_m_inc, w_n_inc, w_sel_m, w_sel_n;
    logic [ICW-1:0] r_k, w_k_inc, w_sel_k;
    logic w_cy_n, w_cy_m, w_cy_c, w_cy_j, w_cy_i;

    logic              r_valid, r_busy, r_done, r_pad, r_first, r_last, r_final;
    logic [FM_AW-1:0]  r_fm, w_fm;
    logic [W_AW-1:0]   r_w, w_w;
    logic [B_AW-1:0]   r_b, w_b;
    logic [OUT_AW-1:0] r_out, w_out;
    logic w_pad, w_first, w_last, w_final;
    logic w_valid_nxt, w_busy_nxt, w_done_nxt, w_load, w_load_zero;

    always_comb begin
        w_cy_n = (r_k == ICW'(IN_CHANNELS - 1));
        w_cy_m = w_cy_n && (r_n == KW'(KERNEL_SIZE - 1));
        w_cy_c = w_cy_m && (r_m == KW'(KERNEL_SIZE - 1));
        w_cy_j = w_cy_c && (r_c == CW'(OUT_CHANNELS - 1));
        w_cy_i = w_cy_j && (r_j == IW'(IN_WIDTH - 1));

        w_k_inc = w_cy_n ? '0 : r_k + 1'b1;
        w_n_inc = !w_cy_n ? r_n : (w_cy_m ? '0 : r_n + 1'b1);
        w_m_inc = !w_cy_m ? r_m : (w_cy_c ? '0 : r_m + 1'b1);
        w_c_inc = !w_cy_c ? r_c : (w_cy_j ? '0 : r_c + 1'b1);
        w_j_inc = !w_cy_j ? r_j : (w_cy_i ? '0 : r_j + 1'b1);
        w_i_inc = !w_cy_i ? r_i : ((r_i == IW'(IN_WIDTH - 1)) ? '0 : r_i + 1'b1);
    end

    assign w_sel_i = w_load_zero ? '0 : w_i_inc;
    assign w_sel_j = w_load_zero ? '0 : w_j_inc;
    assign w_sel_c = w_load_zero ? '0 : w_c_inc;
    assign w_sel_m = w_load_zero ? '0 : w_m_inc;
    assign w_sel_n = w_load_zero ? '0 : w_n_inc;
    assign w_sel_k = w_load_zero ? '0 : w_k_inc;

    conv_addr_gen #(
        .IN_WIDTH     (IN_WIDTH),
        .IN_CHANNELS  (IN_CHANNELS),
        .OUT_CHANNELS (OUT_CHANNELS),
        .KERNEL_SIZE  (KERNEL_SIZE),
        .PADDING      (PADDING)
    ) u_addr_gen (
        .idx_i     (w_sel_i),
        .idx_j     (w_sel_j),
        .idx_c     (w_sel_c),
        .idx_m     (w_sel_m),
        .idx_n     (w_sel_n),
        .idx_k     (w_sel_k),
        .fm_addr   (w_fm),
        .w_addr    (w_w),
        .bias_addr (w_b),
        .out_addr  (w_out),
        .pad_zero  (w_pad),
        .acc_first (w_first),
        .acc_last  (w_last),
        .is_final  (w_final)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_load_zero = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_load      = 1'b1;
                    w_load_zero = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_valid && bus.issue_ready) begin
                    if (r_final) begin
                        w_state_nxt = ST_DONE;
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // start is deliberately not sampled here
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_c     <= '0;
            r_m     <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_fm    <= '0;
            r_w     <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_pad   <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_final <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_i     <= w_sel_i;
                r_j     <= w_sel_j;
                r_c     <= w_sel_c;
                r_m     <= w_sel_m;
                r_n     <= w_sel_n;
                r_k     <= w_sel_k;
                r_fm    <= w_fm;
                r_w     <= w_w;
                r_b     <= w_b;
                r_out   <= w_out;
                r_pad   <= w_pad;
                r_first <= w_first;
                r_last  <= w_last;
                r_final <= w_final;
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign bus.issue_valid = r_valid;
    assign bus.fm_addr     = r_fm;
    assign bus.w_addr      = r_w;
    assign bus.bias_addr   = r_b;
    assign bus.out_addr    = r_out;
    assign bus.pad_zero    = r_pad;
    assign bus.acc_first   = r_first;
    assign bus.acc_last    = r_last;

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_conv_sequencer
// Brief    : Directed self-checking bench for conv_sequencer (W=4,K=3,P=1).
// Revision : 1.0 - initial release
//==============================================================================
module tb_conv_sequencer;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst, start, start2;
    logic busy, done, busy2, done2;

    always #5 clk = ~clk;

    conv_sequencer_if #(.IN_WIDTH(4), .IN_CHANNELS(1), .OUT_CHANNELS(2), .KERNEL_SIZE(3)) bus1 ();
    conv_sequencer_if #(.IN_WIDTH(4), .IN_CHANNELS(2), .OUT_CHANNELS(3), .KERNEL_SIZE(3)) bus2 ();

    conv_sequencer #(.IN_WIDTH(4), .IN_CHANNELS(1), .OUT_CHANNELS(2), .KERNEL_SIZE(3), .PADDING(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus1.master));

    conv_sequencer #(.IN_WIDTH(4), .IN_CHANNELS(2), .OUT_CHANNELS(3), .KERNEL_SIZE(3), .PADDING(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .bus(bus2.master));

    int n_checks = 0;
    int n_errors = 0;

    int rec_fm [0:1023];
    int rec_w  [0:1023];
    int rec_b  [0:1023];
    int rec_out[0:1023];
    int rec_fl [0:1023];   // {pad_zero, acc_first, acc_last}
    int rel, beat_cnt, done_cnt, busy_cnt, last_acc_rel, done_rel, first_busy_rel, stall_left;
    int beat2_cnt, b2_fm, b2_w, b2_b, b2_out, b2_fl;

    task automatic check_value(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int flags1();
        return {29'd0, bus1.pad_zero, bus1.acc_first, bus1.acc_last};
    endfunction

    task automatic sample();
        @(negedge clk);
        if (busy) begin
            busy_cnt++;
            if (first_busy_rel < 0) first_busy_rel = rel;
        end
        if (done) begin
            done_cnt++;
            done_rel = rel;
        end
        if (bus1.issue_valid && bus1.issue_ready) begin
            if (beat_cnt < 1024) begin
                rec_fm[beat_cnt]  = int'(bus1.fm_addr);
                rec_w[beat_cnt]   = int'(bus1.w_addr);
                rec_b[beat_cnt]   = int'(bus1.bias_addr);
                rec_out[beat_cnt] = int'(bus1.out_addr);
                rec_fl[beat_cnt]  = flags1();
            end
            last_acc_rel = rel;
            beat_cnt++;
        end
        if (bus2.issue_valid && bus2.issue_ready) begin
            if (beat2_cnt == 323) begin
                b2_fm  = int'(bus2.fm_addr);
                b2_w   = int'(bus2.w_addr);
                b2_b   = int'(bus2.bias_addr);
                b2_out = int'(bus2.out_addr);
                b2_fl  = {29'd0, bus2.pad_zero, bus2.acc_first, bus2.acc_last};
            end
            beat2_cnt++;
        end
    endtask

    task automatic clear_stats();
        beat_cnt = 0; done_cnt = 0; busy_cnt = 0;
        last_acc_rel = -1; done_rel = -1; first_busy_rel = -1;
    endtask

    // One layer pass on dut1; start at rel 0, optional extra start pulses,
    // a stall of stall_len cycles while beat 5 is presented, optional reset.
    task automatic run_pass(input int stall_len, input int p1, input int p2, input int rst_at);
        clear_stats();
        stall_left = stall_len;
        for (int r = 0; r < 400; r++) begin
            rel = r;
            start = (r == 0) || (r == p1) || (r == p2);
            if (r == rst_at) rst = 1'b1;
            if (stall_left > 0 && beat_cnt == 5 && bus1.issue_valid) begin
                bus1.issue_ready = 1'b0;
                stall_left--;
            end else begin
                bus1.issue_ready = 1'b1;
            end
            sample();
            if (r == rst_at) begin
                check_value("rst_busy",  busy, 0);
                check_value("rst_done",  done, 0);
                check_value("rst_valid", bus1.issue_valid, 0);
                check_value("rst_fm",    bus1.fm_addr, 0);
                check_value("rst_w",     bus1.w_addr, 0);
                check_value("rst_out",   bus1.out_addr, 0);
                check_value("rst_flags", flags1(), 0);
                break;
            end
            if (!bus1.issue_ready) begin
                check_value("stall_fm",    bus1.fm_addr, 1);
                check_value("stall_w",     bus1.w_addr, 10);
                check_value("stall_flags", flags1(), 0);
            end
            @(posedge clk);
            #1;
            if (done_rel >= 0 && r > done_rel + 2) break;
        end
        start = 1'b0;
        bus1.issue_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        bus1.issue_ready = 1'b1;
        bus2.issue_ready = 1'b1;
        beat2_cnt = 0; rel = 0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_value("reset_busy",  busy, 0);
        check_value("reset_valid", bus1.issue_valid, 0);
        check_value("reset_out",   bus1.out_addr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Full pass with starts at rel 10 (mid-run) and 289 (done cycle)
        run_pass(0, 10, 289, -1);
        check_value("p1_beats",      beat_cnt, 288);
        check_value("p1_done_cnt",   done_cnt, 1);
        check_value("p1_done_rel",   done_rel, 289);
        check_value("p1_last_acc",   last_acc_rel, 288);
        check_value("p1_busy_cnt",   busy_cnt, 289);
        check_value("p1_busy_first", first_busy_rel, 1);
        check_value("b0_flags", rec_fl[0], 3'b110);
        check_value("b0_w",     rec_w[0], 0);
        check_value("b0_out",   rec_out[0], 0);
        check_value("b4_fm",    rec_fm[4], 0);
        check_value("b4_w",     rec_w[4], 8);
        check_value("b4_flags", rec_fl[4], 3'b000);
        check_value("b8_flags", rec_fl[8], 3'b001);
        check_value("b8_fm",    rec_fm[8], 5);
        check_value("b9_out",   rec_out[9], 1);
        check_value("b9_bias",  rec_b[9], 1);
        check_value("b9_flags", rec_fl[9], 3'b110);
        check_value("b287_out", rec_out[287], 31);
        check_value("b287_w",   rec_w[287], 17);
        check_value("b287_flags", rec_fl[287], 3'b101);

        // Backpressure: three stall cycles on beat 5
        run_pass(3, -1, -1, -1);
        check_value("p2_beats",    beat_cnt, 288);
        check_value("p2_last_acc", last_acc_rel, 291);
        check_value("p2_done_rel", done_rel, 292);
        check_value("p2_done_cnt", done_cnt, 1);
        check_value("b5_fm",       rec_fm[5], 1);
        check_value("b5_w",        rec_w[5], 10);

        // Reset in the middle of a pass, then a clean restart
        run_pass(0, -1, -1, 100);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_stats();
        for (int r = 0; r < 5; r++) begin
            rel = r;
            sample();
            @(posedge clk);
            #1;
        end
        check_value("post_rst_done", done_cnt, 0);
        check_value("post_rst_busy", busy_cnt, 0);
        run_pass(0, -1, -1, -1);
        check_value("p4_b0_out",   rec_out[0], 0);
        check_value("p4_b0_flags", rec_fl[0], 3'b110);
        check_value("p4_beats",    beat_cnt, 288);
        check_value("p4_done_cnt", done_cnt, 1);

        // IC=2, OC=3 instance: beat (i=1,j=1,c=2,m=2,n=2,k=1) is beat 323
        beat2_cnt = 0;
        start2 = 1'b1;
        for (int r = 0; r < 600; r++) begin
            rel = r;
            sample();
            @(posedge clk);
            #1 start2 = 1'b0;
            if (beat2_cnt > 323) break;
        end
        check_value("c2_reached", (beat2_cnt > 323), 1);
        check_value("c2_fm",    b2_fm, 21);
        check_value("c2_w",     b2_w, 53);
        check_value("c2_out",   b2_out, 17);
        check_value("c2_bias",  b2_b, 2);
        check_value("c2_flags", b2_fl, 3'b001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
